// File: rtl/nios_system_button_ctrl.sv
// nios_system_button_ctrl: Avalon-MM pushbutton/switch port with sync, debounce, edge capture and irq.
// Optional: `define BUTTON_DEBOUNCE_EN adds per-channel debounce counters and the DEB_PERIOD register.
`default_nettype none

module nios_system_button_ctrl #(
    parameter int               WIDTH        = 4,
    parameter int               CNT_W        = 20,
    parameter int               DEB_RESET    = 50000,
    parameter logic [WIDTH-1:0] IN_RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] c_ADDR_DATA = 3'd0;
    localparam logic [2:0] c_ADDR_RISE = 3'd1;
    localparam logic [2:0] c_ADDR_MASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE = 3'd3;
    localparam logic [2:0] c_ADDR_FALL = 3'd4;
    localparam logic [2:0] c_ADDR_DEB  = 3'd5;
    localparam logic [2:0] c_ADDR_RAW  = 3'd6;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdmux;
    logic             w_wr;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_unused = ^{1'b0, writedata};

`ifdef BUTTON_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] c_DEB_RESET = DEB_RESET[CNT_W-1:0];

    logic [CNT_W-1:0] r_deb_period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_period <= c_DEB_RESET;
        end else if (w_wr && (address == c_ADDR_DEB)) begin
            r_deb_period <= writedata[CNT_W-1:0];
        end
    end

    // A channel only moves once the synchronised level has differed for period+1 cycles.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
        logic [CNT_W-1:0] r_cnt;
        logic             r_stb;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_stb <= IN_RESET_VAL[gi];
            end else if (r_s2[gi] == r_stb) begin
                r_cnt <= '0;
            end else if (r_cnt >= r_deb_period) begin
                r_stb <= r_s2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_stable[gi] = r_stb;
    end
`else
    localparam int c_unused_deb = CNT_W + DEB_RESET;

    assign w_stable = r_s2;
`endif

    assign w_edge = (w_stable & ~r_stable_d & r_rise_en)
                  | (~w_stable & r_stable_d & r_fall_en);
    assign w_clr  = (w_wr && (address == c_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rdmux = '0;
        case (address)
            c_ADDR_DATA: w_rdmux[WIDTH-1:0] = w_stable;
            c_ADDR_RISE: w_rdmux[WIDTH-1:0] = r_rise_en;
            c_ADDR_MASK: w_rdmux[WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGE: w_rdmux[WIDTH-1:0] = r_edge_cap;
            c_ADDR_FALL: w_rdmux[WIDTH-1:0] = r_fall_en;
`ifdef BUTTON_DEBOUNCE_EN
            c_ADDR_DEB:  w_rdmux[CNT_W-1:0] = r_deb_period;
`endif
            c_ADDR_RAW:  w_rdmux[WIDTH-1:0] = r_s2;
            default:     w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1       <= IN_RESET_VAL;
            r_s2       <= IN_RESET_VAL;
            r_stable_d <= IN_RESET_VAL;
            r_rise_en  <= '1;
            r_fall_en  <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_stable_d <= w_stable;
            r_readdata <= w_rdmux;
            // A new edge in the clearing cycle survives the write-1-to-clear.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr && (address == c_ADDR_RISE)) begin
                r_rise_en <= writedata[WIDTH-1:0];
            end
            if (w_wr && (address == c_ADDR_FALL)) begin
                r_fall_en <= writedata[WIDTH-1:0];
            end
            if (w_wr && (address == c_ADDR_MASK)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_nios_system_button_ctrl.sv
// tb_nios_system_button_ctrl: directed register table plus timed sequences for edge capture and debounce.
`default_nettype none

module tb_nios_system_button_ctrl;

`ifdef BUTTON_DEBOUNCE_EN
    localparam int          c_STB   = 5;
    localparam logic [31:0] c_PWR   = 32'd3;
    localparam logic [31:0] c_PEXP  = 32'd3;
    localparam logic [31:0] c_PRST  = 32'd50000;
`else
    localparam int          c_STB   = 1;
    localparam logic [31:0] c_PWR   = 32'd7;
    localparam logic [31:0] c_PEXP  = 32'd0;
    localparam logic [31:0] c_PRST  = 32'd0;
`endif
    localparam int c_CAP = c_STB + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    nios_system_button_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        logic [31:0] d;

        tbl[0]  = '{1'b1, 3'd1, 32'h5,        32'h5, "rise_rw"};
        tbl[1]  = '{1'b1, 3'd1, 32'hFFFFFFF0, 32'h0, "rise_upper"};
        tbl[2]  = '{1'b1, 3'd1, 32'hF,        32'hF, "rise_restore"};
        tbl[3]  = '{1'b1, 3'd2, 32'hA,        32'hA, "mask_rw"};
        tbl[4]  = '{1'b1, 3'd2, 32'h0,        32'h0, "mask_clear"};
        tbl[5]  = '{1'b1, 3'd4, 32'h6,        32'h6, "fall_rw"};
        tbl[6]  = '{1'b1, 3'd4, 32'h0,        32'h0, "fall_clear"};
        tbl[7]  = '{1'b1, 3'd0, 32'hF,        32'h0, "data_ro"};
        tbl[8]  = '{1'b1, 3'd6, 32'hF,        32'h0, "raw_ro"};
        tbl[9]  = '{1'b1, 3'd7, 32'hF,        32'h0, "addr7"};
        tbl[10] = '{1'b1, 3'd5, c_PWR,        c_PEXP, "deb_period"};
        tbl[11] = '{1'b0, 3'd3, 32'h0,        32'h0, "capture_idle"};

        idle(3);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd1, d); chk("rst_rise_en", d, 32'hF);
        rd(3'd2, d); chk("rst_mask", d, 32'h0);
        rd(3'd3, d); chk("rst_capture", d, 32'h0);
        rd(3'd4, d); chk("rst_fall_en", d, 32'h0);
        rd(3'd5, d); chk("rst_period", d, c_PRST);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, d);
            chk(tbl[i].name, d, tbl[i].exp_rd);
        end

        // Latency of a rising edge on channel 0, observed on irq and DATA.
        wr(3'd2, 32'h1);
        @(negedge clk);
        address = 3'd0;
        in_port = 4'h1;
        repeat (c_STB + 1) @(negedge clk);
        chk("lat_irq_early", {31'b0, irq}, 32'h0);
        chk("lat_data_early", readdata, 32'h0);
        @(negedge clk);
        chk("lat_irq", {31'b0, irq}, 32'h1);
        chk("lat_data", readdata, 32'h1);
        rd(3'd6, d); chk("raw_level", d, 32'h1);
        rd(3'd3, d); chk("capture_bit0", d, 32'h1);

        wr(3'd2, 32'h0);
        chk("masked_irq", {31'b0, irq}, 32'h0);
        wr(3'd2, 32'h1);
        chk("unmask_irq", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h1);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        rd(3'd3, d); chk("w1c_capture", d, 32'h0);

`ifdef BUTTON_DEBOUNCE_EN
        @(negedge clk);
        in_port = 4'h3;
        idle(3);
        in_port = 4'h1;
        idle(8);
        rd(3'd0, d); chk("glitch3_data", d, 32'h1);
        rd(3'd3, d); chk("glitch3_capture", d, 32'h0);
        @(negedge clk);
        in_port = 4'h3;
        idle(4);
        in_port = 4'h1;
        idle(8);
        rd(3'd3, d); chk("pulse4_capture", d, 32'h2);
        wr(3'd3, 32'h2);
`endif

        // Falling-edge only on channel 2.
        wr(3'd4, 32'h4);
        wr(3'd1, 32'h0);
        @(negedge clk);
        in_port = 4'h5;
        idle(10);
        rd(3'd3, d); chk("fall_no_rise", d, 32'h0);
        in_port = 4'h1;
        idle(10);
        rd(3'd3, d); chk("fall_capture", d, 32'h4);
        wr(3'd3, 32'h4);
        wr(3'd4, 32'h0);
        wr(3'd1, 32'hF);

        // Selective clear, then clear racing a new edge.
        in_port = 4'h0;
        idle(10);
        in_port = 4'h3;
        idle(10);
        rd(3'd3, d); chk("cap_two", d, 32'h3);
        wr(3'd3, 32'h1);
        rd(3'd3, d); chk("w1c_one", d, 32'h2);
        in_port = 4'h1;
        idle(10);
        wr(3'd3, 32'h2);
        rd(3'd3, d); chk("w1c_bit1", d, 32'h0);
        @(negedge clk);
        in_port = 4'h3;
        repeat (c_CAP) @(negedge clk);
        address    = 3'd3;
        writedata  = 32'h2;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd3, d); chk("set_wins", d, 32'h2);

        // Asynchronous reset in the middle of a debounce.
        wr(3'd2, 32'hF);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        address = 3'd1;
        in_port = 4'h0;
        idle(2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_readdata", readdata, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        idle(2);
        reset_n = 1'b1;
        rd(3'd1, d); chk("post_rst_rise_en", d, 32'hF);
        rd(3'd5, d); chk("post_rst_period", d, c_PRST);
        idle(6);
        rd(3'd3, d); chk("post_rst_capture", d, 32'h0);
        rd(3'd2, d); chk("post_rst_mask", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
